pulse_period_meter: RTL

- Measures an asynchronous digital input and reports its high time and period as clock-cycle counts.
- It is the inverse of the counter-plus-threshold compare path used for clock division. That path turns a count into a waveform; this block turns a waveform back into counts.
- It sits behind a divided-clock or PWM output for self-check, or on an external pin, and feeds a consumer through a valid/ack handshake.

---
 rtl/pulse_period_meter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// Measures the high time and period of an asynchronous input in clock cycles,
// presenting each completed period to a consumer through a valid/ack handshake.
module pulse_period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] high_count,
  output logic [WIDTH-1:0] period_count,
  output logic             meas_valid,
  input  logic             meas_ack,
  output logic             overrun,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s_d_p1;
  logic                   s;
  logic                   rise;
  logic                   fall;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_cap, hi_cap_nxt;
  logic             close;
  logic             ovf_set;
  logic             load;
  logic             drop;
  logic             valid_nxt;
  logic             overrun_nxt;
  logic             overflow_nxt;

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d_p1;
  assign fall = ~s & s_d_p1;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_cap_nxt = hi_cap;
    close      = 1'b0;
    ovf_set    = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          // Only a rising edge opens a period, so no partial period is ever reported.
          if (rise) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_cap_nxt = cnt;
            cnt_nxt    = sat_inc(cnt);
            state_nxt  = LOW;
          end else if (cnt == CNT_MAX) begin
            ovf_set   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        LOW: begin
          if (rise) begin
            close     = 1'b1;
            cnt_nxt   = CNT_ONE;
            state_nxt = HIGH;
          end else if (cnt == CNT_MAX) begin
            ovf_set   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = sat_inc(cnt);
          end
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end

    // A result pending un-acked when the next one closes is lost, old one kept.
    load         = close & (~meas_valid | meas_ack);
    drop         = close & ~load;
    valid_nxt    = load ? 1'b1 : (meas_ack ? 1'b0 : meas_valid);
    overrun_nxt  = enable ? (overrun | drop) : 1'b0;
    overflow_nxt = enable ? (overflow | ovf_set) : 1'b0;
  end

  // Synchroniser and edge-detect stage
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      s_d_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      s_d_p1  <= s;
    end
  end

  // Measurement state and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_cap       <= '0;
      high_count   <= '0;
      period_count <= '0;
      meas_valid   <= 1'b0;
      overrun      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hi_cap     <= hi_cap_nxt;
      meas_valid <= valid_nxt;
      overrun    <= overrun_nxt;
      overflow   <= overflow_nxt;
      if (load) begin
        high_count   <= hi_cap;
        period_count <= cnt;
      end
    end
  end

endmodule
